// File: rtl/nap_countdown_pkg.sv
// Shared types and BCD limits for the nap countdown timer and its digit cells.
// Time is carried as a packed HH:MM:SS record of six BCD nibbles.
package nap_countdown_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_ALARM  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_ONE_MAX     = 4'd9;
  localparam logic [3:0] BCD_TEN_MAX     = 4'd5;
  localparam logic [3:0] HOUR_TEN_MAX    = 4'd2;
  localparam logic [3:0] HOUR_ONE_MAX_HI = 4'd3;

  typedef struct packed {
    logic [3:0] hour_ten;
    logic [3:0] hour_one;
    logic [3:0] min_ten;
    logic [3:0] min_one;
    logic [3:0] sec_ten;
    logic [3:0] sec_one;
  } bcd_time_t;

endpackage

// File: rtl/nap_countdown_bcd_down_digit.sv
// One BCD digit of the countdown borrow chain: decrements when borrowed from,
// wrapping 0 to MAX and passing the borrow on to the next-higher digit.
module bcd_down_digit
  import nap_countdown_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_ONE_MAX
) (
  input  logic [3:0] value,
  input  logic       borrow_in,
  output logic [3:0] next_value,
  output logic       borrow_out
);

  always_comb begin
    next_value = value;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (value == 4'd0) begin
        next_value = MAX;
        borrow_out = 1'b1;
      end else begin
        next_value = value - 4'd1;
      end
    end
  end

endmodule

// File: rtl/nap_countdown.sv
// Nap countdown timer: validates and loads an HH:MM:SS BCD time, counts it down
// once per prescaler tick with start/pause/cancel, and latches an alarm at zero.
module nap_countdown
  import nap_countdown_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] hour_ten_in,
  input  logic [3:0] hour_one_in,
  input  logic [3:0] min_ten_in,
  input  logic [3:0] min_one_in,
  input  logic [3:0] sec_ten_in,
  input  logic [3:0] sec_one_in,
  input  logic       start,
  input  logic       cancel,
  input  logic       alarm_ack,
  output logic [3:0] hour_ten_out,
  output logic [3:0] hour_one_out,
  output logic [3:0] min_ten_out,
  output logic [3:0] min_one_out,
  output logic [3:0] sec_ten_out,
  output logic [3:0] sec_one_out,
  output logic       running,
  output logic       alarm,
  output logic       done,
  output logic       load_err
);

  localparam int              PS_W    = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  state_t          state;
  state_t          state_n;
  bcd_time_t       cur;
  bcd_time_t       cur_n;
  bcd_time_t       set_in;
  bcd_time_t       dec;
  logic [PS_W-1:0] ps;
  logic [PS_W-1:0] ps_n;
  logic            done_n;
  logic            err_n;

  logic [3:0] nxt_s1, nxt_s10, nxt_m1, nxt_m10, nxt_h1, nxt_h10;
  logic       b_s1, b_s10, b_m1, b_m10, b_h1, b_h10;

  function automatic logic load_ok(input bcd_time_t t);
    logic ones_ok;
    logic tens_ok;
    logic hours_ok;
    ones_ok  = (t.hour_one <= BCD_ONE_MAX) && (t.min_one <= BCD_ONE_MAX) &&
               (t.sec_one <= BCD_ONE_MAX);
    tens_ok  = (t.min_ten <= BCD_TEN_MAX) && (t.sec_ten <= BCD_TEN_MAX);
    hours_ok = (t.hour_ten <= HOUR_TEN_MAX) &&
               !((t.hour_ten == HOUR_TEN_MAX) && (t.hour_one > HOUR_ONE_MAX_HI));
    return ones_ok && tens_ok && hours_ok && (t != '0);
  endfunction

  assign set_in = {hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in};

  // Borrow chain: the seconds-ones digit is always borrowed from on a tick.
  bcd_down_digit #(.MAX(BCD_ONE_MAX)) u_sec_one (
    .value(cur.sec_one), .borrow_in(1'b1), .next_value(nxt_s1), .borrow_out(b_s1)
  );
  bcd_down_digit #(.MAX(BCD_TEN_MAX)) u_sec_ten (
    .value(cur.sec_ten), .borrow_in(b_s1), .next_value(nxt_s10), .borrow_out(b_s10)
  );
  bcd_down_digit #(.MAX(BCD_ONE_MAX)) u_min_one (
    .value(cur.min_one), .borrow_in(b_s10), .next_value(nxt_m1), .borrow_out(b_m1)
  );
  bcd_down_digit #(.MAX(BCD_TEN_MAX)) u_min_ten (
    .value(cur.min_ten), .borrow_in(b_m1), .next_value(nxt_m10), .borrow_out(b_m10)
  );
  bcd_down_digit #(.MAX(BCD_ONE_MAX)) u_hour_one (
    .value(cur.hour_one), .borrow_in(b_m10), .next_value(nxt_h1), .borrow_out(b_h1)
  );
  bcd_down_digit #(.MAX(HOUR_TEN_MAX)) u_hour_ten (
    .value(cur.hour_ten), .borrow_in(b_h1), .next_value(nxt_h10), .borrow_out(b_h10)
  );

  assign dec = {nxt_h10, nxt_h1, nxt_m10, nxt_m1, nxt_s10, nxt_s1};

  always_comb begin
    state_n = state;
    cur_n   = cur;
    ps_n    = ps;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (cancel) begin
      state_n = ST_IDLE;
      cur_n   = '0;
      ps_n    = '0;
    end else if (load && ((state == ST_IDLE) || (state == ST_LOADED))) begin
      if (load_ok(set_in)) begin
        cur_n   = set_in;
        state_n = ST_LOADED;
      end else begin
        err_n = 1'b1;
      end
    end else begin
      unique case (state)
        ST_LOADED: begin
          if (start) begin
            state_n = ST_RUN;
            ps_n    = '0;
          end
        end
        ST_RUN: begin
          if (ps == PS_LAST) begin
            ps_n = '0;
            // An underflow out of the hour-tens digit can only mean the count
            // was already zero; treat it as expiry rather than wrapping.
            if (b_h10 || (dec == '0)) begin
              state_n = ST_ALARM;
              cur_n   = '0;
              done_n  = 1'b1;
            end else begin
              cur_n = dec;
              if (start) state_n = ST_PAUSE;
            end
          end else if (start) begin
            state_n = ST_PAUSE;
          end else begin
            ps_n = ps + PS_W'(1);
          end
        end
        ST_PAUSE: begin
          if (start) state_n = ST_RUN;
        end
        ST_ALARM: begin
          if (alarm_ack) state_n = ST_IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cur      <= '0;
      ps       <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
      running  <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      ps       <= ps_n;
      done     <= done_n;
      load_err <= err_n;
      running  <= (state_n == ST_RUN);
      alarm    <= (state_n == ST_ALARM);
    end
  end

  assign hour_ten_out = cur.hour_ten;
  assign hour_one_out = cur.hour_one;
  assign min_ten_out  = cur.min_ten;
  assign min_one_out  = cur.min_one;
  assign sec_ten_out  = cur.sec_ten;
  assign sec_one_out  = cur.sec_one;

endmodule
